fft_r4_sequencer: RTL and testbench

- Parametrised successor to the fixed 512-word-per-bank FFT control path.
- Sequences a complete in-place radix-4 FFT over 4 RAM banks with A/B ping-pong: streaming load, N_STAGE compute passes, streaming unload in natural order.
- Replaces externally driven load/unload addresses and write enables with valid/ready handshakes.
- Drives the bank RAMs, input/output mixes, butterfly-type select and twiddle ROMs in the FFT top.

---
 rtl/fft_seq_pkg.sv | 50 +++++
 rtl/fft_seq_delay.sv | 36 +++
 rtl/fft_r4_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_fft_r4_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_seq_pkg.sv
// Shared types, default sizing and index helpers for the radix-4 FFT sequencer.
// Helpers work on 32-bit values; callers cast results down to their own widths.
package fft_seq_pkg;

    localparam int unsigned DEF_ADDR_W  = 8;
    localparam int unsigned DEF_N       = 4 << DEF_ADDR_W;
    localparam int unsigned DEF_N_STAGE = (DEF_ADDR_W + 2) / 2;
    localparam int unsigned DEF_STAGE_W = $clog2(DEF_N_STAGE + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StComp,
        StFlush,
        StUnload
    } state_e;

    // Reverse the order of the lowest ndig base-4 digits of idx.
    function automatic logic [31:0] digit_rev4(input logic [31:0] idx, input int ndig);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < ndig) begin
                r = {r[29:0], idx[2*i +: 2]};
            end
        end
        return r;
    endfunction

    function automatic logic [1:0] digit_sum4_mod4(input logic [31:0] g);
        logic [1:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            acc = acc + g[2*i +: 2];
        end
        return acc;
    endfunction

    // Rotate the low w bits of g left by sh (taken modulo w).
    function automatic logic [31:0] rotl(input logic [31:0] g, input int sh, input int w);
        logic [31:0] mask;
        logic [31:0] r;
        int          s;
        s    = sh % w;
        mask = (32'd1 << w) - 32'd1;
        r    = g & mask;
        return ((r << s) | (r >> (w - s))) & mask;
    endfunction

endpackage

// File: rtl/fft_seq_delay.sv
// Fixed-latency shift register carrying the {valid, addr, rot} write tuple.
module fft_seq_delay #(
    parameter int unsigned DEPTH = 6,
    parameter int unsigned W     = 11
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] tuple_i,
    output logic [W-1:0] tuple_o
);

    logic [W-1:0] pipe_q [DEPTH];
    logic [W-1:0] pipe_d [DEPTH];

    always_comb begin
        pipe_d[0] = tuple_i;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign tuple_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_r4_sequencer.sv
// Control path for an in-place radix-4 FFT over four RAM banks with A/B ping-pong:
// handshaked load, N_STAGE compute passes, handshaked digit-reversed unload.
module fft_r4_sequencer #(
    parameter int unsigned ADDR_W   = fft_seq_pkg::DEF_ADDR_W,
    parameter int unsigned N_STAGE  = (ADDR_W + 2) / 2,
    parameter int unsigned PIPE_LAT = 6,
    parameter int unsigned STAGE_W  = $clog2(N_STAGE + 1)
) (
    input  logic               iCLK,
    input  logic               iRESET,
    input  logic               iSTART,
    input  logic               iIN_VALID,
    output logic               oIN_READY,
    output logic               oOUT_VALID,
    input  logic               iOUT_READY,
    output logic               oOUT_LAST,
    output logic [ADDR_W-1:0]  oADDR_RD,
    output logic [1:0]         oBANK_RD_ROT,
    output logic [ADDR_W-1:0]  oADDR_WR,
    output logic [1:0]         oBANK_WR_ROT,
    output logic [3:0]         oWE_A,
    output logic               oWE_B,
    output logic               oSOURCE_DATA,
    output logic               oSOURCE_CONT,
    output logic [ADDR_W-1:0]  oADDR_COEF,
    output logic               oBUT_TYPE,
    output logic [STAGE_W-1:0] oSTAGE,
    output logic               oBUSY,
    output logic               oRDY
);
    import fft_seq_pkg::*;

    localparam int unsigned CNT_W = ADDR_W + 2;
    localparam int unsigned FL_W  = $clog2(PIPE_LAT + 1);
    localparam int unsigned TUP_W = ADDR_W + 3;
    localparam logic [CNT_W-1:0]   LAST_IDX = {CNT_W{1'b1}};
    localparam logic [ADDR_W-1:0]  LAST_G   = {ADDR_W{1'b1}};
    localparam logic [STAGE_W-1:0] LAST_S   = STAGE_W'(N_STAGE - 1);
    localparam logic [FL_W-1:0]    LAST_F   = FL_W'(PIPE_LAT - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    k_q, k_d, m_q, m_d;
    logic [ADDR_W-1:0]   g_q, g_d, laddr_q, laddr_d;
    logic [STAGE_W-1:0]  s_q, s_d;
    logic [FL_W-1:0]     f_q, f_d;
    logic [3:0]          lwe_q, lwe_d;
    logic                vld_q, vld_d, rdy_q, rdy_d;
    logic                in_hs, out_hs;

    logic [ADDR_W-1:0]   rd_addr, coef;
    logic [1:0]          rd_rot;
    logic [CNT_W-1:0]    j;
    logic                but_type, src_data;
    logic [TUP_W-1:0]    wr_in, wr_out;

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q <= StIdle;
            k_q     <= '0;
            m_q     <= '0;
            g_q     <= '0;
            s_q     <= '0;
            f_q     <= '0;
            laddr_q <= '0;
            lwe_q   <= '0;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            m_q     <= m_d;
            g_q     <= g_d;
            s_q     <= s_d;
            f_q     <= f_d;
            laddr_q <= laddr_d;
            lwe_q   <= lwe_d;
            vld_q   <= vld_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        m_d     = m_q;
        g_d     = g_q;
        s_d     = s_q;
        f_d     = f_q;
        vld_d   = vld_q;
        rdy_d   = 1'b0;
        lwe_d   = '0;
        laddr_d = '0;
        in_hs   = 1'b0;
        out_hs  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (iSTART) begin
                    state_d = StLoad;
                    k_d     = '0;
                    s_d     = '0;
                end
            end
            StLoad: begin
                in_hs = iIN_VALID;
                if (in_hs) begin
                    lwe_d   = 4'b0001 << k_q[1:0];
                    laddr_d = k_q[CNT_W-1:2];
                    k_d     = k_q + CNT_W'(1);
                    if (k_q == LAST_IDX) begin
                        k_d     = k_q;
                        state_d = StComp;
                        g_d     = '0;
                        s_d     = '0;
                    end
                end
            end
            StComp: begin
                g_d = g_q + ADDR_W'(1);
                if (g_q == LAST_G) begin
                    g_d     = '0;
                    f_d     = '0;
                    state_d = StFlush;
                end
            end
            StFlush: begin
                f_d = f_q + FL_W'(1);
                if (f_q == LAST_F) begin
                    f_d = '0;
                    if (s_q == LAST_S) begin
                        state_d = StUnload;
                        m_d     = '0;
                        vld_d   = 1'b0;
                    end else begin
                        s_d     = s_q + STAGE_W'(1);
                        state_d = StComp;
                    end
                end
            end
            StUnload: begin
                vld_d  = 1'b1;
                out_hs = vld_q & iOUT_READY;
                if (out_hs) begin
                    if (m_q == LAST_IDX) begin
                        state_d = StIdle;
                        vld_d   = 1'b0;
                        rdy_d   = 1'b1;
                        s_d     = '0;
                    end else begin
                        m_d = m_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // During unload the RAM address follows m_d so a stalled sample keeps its address.
    always_comb begin
        rd_addr  = '0;
        rd_rot   = '0;
        coef     = '0;
        but_type = 1'b0;
        src_data = 1'b0;
        j        = '0;
        if (state_q == StComp) begin
            rd_addr = ADDR_W'(rotl(32'(g_q), 2 * int'(s_q), int'(ADDR_W)));
            rd_rot  = digit_sum4_mod4(32'(g_q));
            coef    = ADDR_W'(32'(g_q) << (2 * int'(s_q)));
        end else if (state_q == StUnload) begin
            j        = CNT_W'(digit_rev4(32'(m_d), int'(N_STAGE)));
            rd_addr  = j[CNT_W-1:2];
            rd_rot   = j[1:0];
            src_data = 1'(N_STAGE % 2);
        end
        if (state_q == StComp || state_q == StFlush) begin
            src_data = s_q[0];
            but_type = (s_q == LAST_S);
            if (but_type) begin
                coef = '0;
            end
        end
    end

    assign wr_in = (state_q == StComp) ? {1'b1, rd_addr, rd_rot} : '0;

    fft_seq_delay #(
        .DEPTH (PIPE_LAT),
        .W     (TUP_W)
    ) u_wr_delay (
        .clk_i   (iCLK),
        .rst_ni  (iRESET),
        .tuple_i (wr_in),
        .tuple_o (wr_out)
    );

    // Load writes and delayed compute writes never overlap, so their fields are OR-merged.
    assign oWE_A        = lwe_q | {4{wr_out[TUP_W-1] & s_q[0]}};
    assign oWE_B        = wr_out[TUP_W-1] & ~s_q[0];
    assign oADDR_WR     = laddr_q | wr_out[TUP_W-2:2];
    assign oBANK_WR_ROT = wr_out[1:0];
    assign oADDR_RD     = rd_addr;
    assign oBANK_RD_ROT = rd_rot;
    assign oADDR_COEF   = coef;
    assign oBUT_TYPE    = but_type;
    assign oSOURCE_DATA = src_data;
    assign oSOURCE_CONT = (state_q == StLoad) | (|lwe_q);
    assign oIN_READY    = (state_q == StLoad);
    assign oOUT_VALID   = vld_q;
    assign oOUT_LAST    = vld_q & (m_q == LAST_IDX);
    assign oSTAGE       = s_q;
    assign oBUSY        = (state_q != StIdle);
    assign oRDY         = rdy_q;

endmodule

// File: tb/tb_fft_r4_sequencer.sv
// Directed bench for fft_r4_sequencer at ADDR_W=2 (N=16, two stages), PIPE_LAT=3.
module tb_fft_r4_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, in_valid, out_ready;
    logic       in_ready, out_valid, out_last;
    logic [1:0] addr_rd, bank_rd, addr_wr, bank_wr, coef, stage;
    logic [3:0] we_a;
    logic       we_b, src_data, src_cont, but_type, busy, rdy;
    logic [24:0] all_outs;

    always #5 clk = ~clk;

    fft_r4_sequencer #(
        .ADDR_W   (2),
        .PIPE_LAT (3)
    ) dut (
        .iCLK         (clk),
        .iRESET       (rst_n),
        .iSTART       (start),
        .iIN_VALID    (in_valid),
        .oIN_READY    (in_ready),
        .oOUT_VALID   (out_valid),
        .iOUT_READY   (out_ready),
        .oOUT_LAST    (out_last),
        .oADDR_RD     (addr_rd),
        .oBANK_RD_ROT (bank_rd),
        .oADDR_WR     (addr_wr),
        .oBANK_WR_ROT (bank_wr),
        .oWE_A        (we_a),
        .oWE_B        (we_b),
        .oSOURCE_DATA (src_data),
        .oSOURCE_CONT (src_cont),
        .oADDR_COEF   (coef),
        .oBUT_TYPE    (but_type),
        .oSTAGE       (stage),
        .oBUSY        (busy),
        .oRDY         (rdy)
    );

    assign all_outs = {in_ready, out_valid, out_last, addr_rd, bank_rd, addr_wr, bank_wr,
                       we_a, we_b, src_data, src_cont, coef, but_type, stage, busy, rdy};

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [3:0] we;
        logic [1:0] addr;
    } wr_t;

    typedef struct packed {
        logic [3:0] m;
        logic [1:0] bank;
        logic [1:0] addr;
        logic       last;
    } rd_t;

    wr_t wr_q[$];
    rd_t rd_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        int          hs;
        int          stalls;
        logic        prev_hs;
        logic [1:0]  prev_bank, prev_addr;
        logic [3:0]  mm;
        logic [3:0]  j;
        logic [3:0]  ew;
        wr_t         w;
        rd_t         e;

        rst_n     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_all_outputs", 32'(all_outs), 32'd0);
        tick();
        rst_n = 1'b1;

        // Run 1: iSTART held high through load and compute must be ignored.
        tick();
        start   = 1'b1;
        k       = 0;
        prev_hs = 1'b0;
        for (int i = 0; i < 31; i++) begin
            tick();
            in_valid = (i % 2 == 0);
            #1;
            chk("load_in_ready", 32'(in_ready), 32'd1);
            chk("load_source_cont", 32'(src_cont), 32'd1);
            if (prev_hs) begin
                w = wr_q.pop_front();
                chk("load_we_a", 32'(we_a), 32'(w.we));
                chk("load_addr_wr", 32'(addr_wr), 32'(w.addr));
            end else begin
                chk("load_we_a_idle", 32'(we_a), 32'd0);
            end
            prev_hs = in_valid;
            if (in_valid) begin
                ew = 4'b0001 << (k % 4);
                wr_q.push_back(wr_t'{we: ew, addr: 2'(k / 4)});
                k++;
            end
        end

        // Two stage periods of 4 reads + 3 flush cycles each.
        for (int c = 0; c < 14; c++) begin
            tick();
            in_valid = 1'b0;
            #1;
            chk("comp_busy", 32'(busy), 32'd1);
            if (c == 0) begin
                w = wr_q.pop_front();
                chk("load_last_we_a", 32'(we_a), 32'(w.we));
                chk("load_last_addr_wr", 32'(addr_wr), 32'(w.addr));
                chk("in_ready_drop", 32'(in_ready), 32'd0);
            end else begin
                chk("comp_we_a", 32'(we_a), (c >= 10 && c <= 13) ? 32'hf : 32'd0);
            end
            chk("comp_we_b", 32'(we_b), (c >= 3 && c <= 6) ? 32'd1 : 32'd0);
            if (c >= 3 && c <= 6) begin
                chk("s0_addr_wr", 32'(addr_wr), 32'(c - 3));
                chk("s0_bank_wr", 32'(bank_wr), 32'(c - 3));
            end
            if (c >= 10 && c <= 13) begin
                chk("s1_addr_wr", 32'(addr_wr), 32'(c - 10));
                chk("s1_bank_wr", 32'(bank_wr), 32'(c - 10));
            end
            if (c <= 3) begin
                chk("s0_addr_rd", 32'(addr_rd), 32'(c));
                chk("s0_bank_rd", 32'(bank_rd), 32'(c));
                chk("s0_coef", 32'(coef), 32'(c));
                chk("s0_src_data", 32'(src_data), 32'd0);
                chk("s0_but_type", 32'(but_type), 32'd0);
                chk("s0_stage", 32'(stage), 32'd0);
            end
            if (c >= 7 && c <= 10) begin
                chk("s1_addr_rd", 32'(addr_rd), 32'(c - 7));
                chk("s1_bank_rd", 32'(bank_rd), 32'(c - 7));
                chk("s1_coef", 32'(coef), 32'd0);
                chk("s1_src_data", 32'(src_data), 32'd1);
                chk("s1_but_type", 32'(but_type), 32'd1);
                chk("s1_stage", 32'(stage), 32'd1);
            end
        end

        // Unload: expected bank/address per output index from base-4 digit reversal.
        for (int m = 0; m < 16; m++) begin
            mm = 4'(m);
            j  = {mm[1:0], mm[3:2]};
            rd_q.push_back(rd_t'{m: mm, bank: j[1:0], addr: j[3:2], last: (m == 15)});
        end
        hs        = 0;
        stalls    = 0;
        prev_bank = '0;
        prev_addr = '0;
        for (int u = 0; u < 40 && hs < 16; u++) begin
            tick();
            start     = 1'b0;
            out_ready = !(out_valid && rd_q.size() > 0 && rd_q[0].m == 4'd5 && stalls < 3);
            if (!out_ready) stalls++;
            #1;
            if (u == 0) begin
                chk("unload_first_valid", 32'(out_valid), 32'd0);
            end
            chk("unload_src_data", 32'(src_data), 32'd0);
            if (out_valid) begin
                if (rd_q.size() == 0) begin
                    chk("unload_extra_sample", 32'd1, 32'd0);
                end else begin
                    e = rd_q[0];
                    chk("unload_bank", 32'(prev_bank), 32'(e.bank));
                    chk("unload_addr", 32'(prev_addr), 32'(e.addr));
                    chk("unload_last", 32'(out_last), 32'(e.last));
                    if (!out_ready) begin
                        chk("stall_hold_bank", 32'(bank_rd), 32'(e.bank));
                        chk("stall_hold_addr", 32'(addr_rd), 32'(e.addr));
                    end else begin
                        void'(rd_q.pop_front());
                        hs++;
                    end
                end
            end
            prev_bank = bank_rd;
            prev_addr = addr_rd;
        end
        chk("unload_handshakes", 32'(hs), 32'd16);
        chk("stall_cycles", 32'(stalls), 32'd3);
        out_ready = 1'b1;
        tick();
        chk("rdy_pulse", 32'(rdy), 32'd1);
        chk("idle_after_run", 32'(busy), 32'd0);
        chk("valid_after_run", 32'(out_valid), 32'd0);
        tick();
        chk("rdy_one_cycle", 32'(rdy), 32'd0);
        repeat (3) tick();
        chk("single_run", 32'(busy), 32'd0);

        // Run 2: reset asserted in stage 1 at g=2.
        start = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        repeat (16) tick();
        in_valid = 1'b0;
        repeat (9) tick();
        chk("pre_reset_addr_rd", 32'(addr_rd), 32'd2);
        chk("pre_reset_stage", 32'(stage), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_all_outputs", 32'(all_outs), 32'd0);
        chk("async_reset_busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;

        // Run 3: restart after reset begins a fresh load at k=0.
        tick();
        start = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        #1;
        chk("restart_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("restart_we_a", 32'(we_a), 32'd1);
        chk("restart_addr_wr", 32'(addr_wr), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
